// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes rx, recovers frames with an internal
// bit-timing counter and holds each byte with ready, framing and overrun flags.
module uart_receiver #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_m, rx_s;
    logic                 shift_en;
    logic                 complete;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
            if (shift_en)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        shift_en = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (!rx_s)
                    state_nx = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    shift_en = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data       <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            // An acknowledge on the completion edge frees the holding register
            if (!data_ready || read_ack) begin
                data       <= shreg;
                data_ready <= 1'b1;
                frame_err  <= ~rx_s;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (read_ack) begin
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: every busy->idle transition is matched
// against the expected holding-register contents and completion cycle.
module tb_uart_receiver;

    localparam int DB  = 8;
    localparam int CPB = 16;
    // stop-sample edge counted from E0: 2 sync edges, half bit, DB data bits + stop
    localparam int STOP_N = 2 + CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          read_ack = 1'b0;
    logic [DB-1:0] data;
    logic          data_ready, frame_err, overrun, busy;

    uart_receiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .read_ack(read_ack),
        .data(data), .data_ready(data_ready), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DB-1:0] d;
        logic          rdy;
        logic          fe;
        logic          ov;
        int unsigned   at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [DB-1:0] m_data = '0;
    logic          m_rdy = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: each return to idle must match the oldest expectation
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got data %0h with empty queue (cycle %0d)", data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("data", 32'(data), 32'(e.d));
                    chk("data_ready", 32'(data_ready), 32'(e.rdy));
                    chk("frame_err", 32'(frame_err), 32'(e.fe));
                    chk("overrun", 32'(overrun), 32'(e.ov));
                    chk("completion_cycle", cyc, e.at);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic push_expect(input int unsigned at);
        sb.push_back('{m_data, m_rdy, m_fe, m_ov, at});
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // abort_at >= 0 asserts reset at that bit-cycle and expects nothing
    task automatic send_frame(input logic [DB-1:0] b, input logic stop,
                              input bit ack_at_stop, input int abort_at);
        int unsigned   k;
        logic [DB+1:0] bits;
        bits = {stop, b, 1'b0};
        for (int n = 0; n < (DB + 2) * CPB; n++) begin
            @(negedge clk);
            if (n == 0 && abort_at < 0) begin
                k = cyc;
                if (!m_rdy || ack_at_stop) begin
                    m_data = b;
                    m_rdy  = 1'b1;
                    m_fe   = ~stop;
                    m_ov   = 1'b0;
                end else begin
                    m_ov = 1'b1;
                end
                push_expect(k + 1 + STOP_N);
                // a low stop bit looks like a new start; it is rejected once rx returns high
                if (!stop)
                    push_expect(k + 1 + STOP_N + 1 + CPB / 2);
            end
            rx       = bits[n / CPB];
            read_ack = ack_at_stop && (n == STOP_N);
            if (n == abort_at) begin
                #3;
                reset = 1'b0;
                return;
            end
        end
        if (!stop) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic glitch(input int len);
        int unsigned k;
        @(negedge clk);
        k = cyc;
        push_expect(k + 1 + 2 + CPB / 2);
        rx = 1'b0;
        repeat (len - 1) @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic ack_check();
        @(negedge clk);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        m_rdy = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        chk("ack_data_ready", 32'(data_ready), 32'(m_rdy));
        chk("ack_frame_err", 32'(frame_err), 32'(m_fe));
        chk("ack_overrun", 32'(overrun), 32'(m_ov));
        chk("ack_data_kept", 32'(data), 32'(m_data));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data"}, 32'(data), 32'h0);
        chk({tag, "_data_ready"}, 32'(data_ready), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;
        idle(4);

        send_frame(8'h48, 1'b1, 1'b0, -1);
        idle(20);
        ack_check();

        send_frame(8'hA5, 1'b0, 1'b0, -1);
        idle(20);
        ack_check();

        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(20);
        ack_check();
        send_frame(8'h33, 1'b1, 1'b0, -1);
        idle(20);
        ack_check();

        glitch(6);
        idle(20);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(20);
        ack_check();

        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle(10);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        idle(20);

        // abort mid bit 4 while 0x5A is still held
        send_frame(8'hE7, 1'b1, 1'b0, 5 * CPB + 5);
        #1;
        check_cleared("abort");
        m_data = '0;
        m_rdy  = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(20);
        ack_check();

        for (int i = 0; i < 16; i++) begin
            logic [DB-1:0] b;
            logic          stop;
            bit            ack_stop;
            b        = DB'($urandom);
            stop     = ($urandom_range(0, 3) != 0);
            ack_stop = ($urandom_range(0, 3) == 0);
            send_frame(b, stop, ack_stop, -1);
            if (stop && $urandom_range(0, 2) == 0)
                continue;
            idle($urandom_range(20, 40));
            if ($urandom_range(0, 1) == 1)
                ack_check();
        end

        idle(40);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
